// File: rtl/mobilenet_pkg.sv
// Shared constants, lane packing helpers and FSM state type for the
// MobileNet tail (global average pool feeding the fc layer).
package mobilenet_pkg;

    localparam int GAP_NUM_PIXELS = 49;
    localparam int GAP_RECIP      = 1337;
    localparam int GAP_ACC_WIDTH  = 14;
    localparam int FC_TOTAL_COUNT = 1024;
    localparam int GAP_LANE_WIDTH = 8;
    localparam int GAP_WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINAL,
        DONE
    } gap_state_t;

    // Channel 4k+n lives in byte n of word k.
    function automatic logic [GAP_LANE_WIDTH-1:0] lane_unpack(
        input logic [GAP_WORD_WIDTH-1:0] word,
        input int unsigned               n
    );
        return word[n*GAP_LANE_WIDTH +: GAP_LANE_WIDTH];
    endfunction

    function automatic logic [GAP_WORD_WIDTH-1:0] lane_pack(
        input logic [GAP_WORD_WIDTH-1:0] word,
        input int unsigned               n,
        input logic [GAP_LANE_WIDTH-1:0] val
    );
        logic [GAP_WORD_WIDTH-1:0] r;
        r = word;
        r[n*GAP_LANE_WIDTH +: GAP_LANE_WIDTH] = val;
        return r;
    endfunction

endpackage

// File: rtl/global_avg_pool_if.sv
// FIFO-side bus of the pooling stage: input FIFO pop side and fc operand
// FIFO push side. The pooling stage is the master.
interface global_avg_pool_if #(
    parameter int WORD_WIDTH = 32
);
    logic [WORD_WIDTH-1:0] in_dout;
    logic                  in_empty;
    logic                  in_rd_en;
    logic                  out_almost_full;
    logic                  out_wr_en;
    logic [WORD_WIDTH-1:0] out_din;

    modport master (
        input  in_dout, in_empty, out_almost_full,
        output in_rd_en, out_wr_en, out_din
    );

    modport slave (
        output in_dout, in_empty, out_almost_full,
        input  in_rd_en, out_wr_en, out_din
    );
endinterface

// File: rtl/gap_acc_ram.sv
// Simple dual-port accumulator RAM with a one-cycle registered read port.
// Read-during-write to the same address returns the old contents.
module gap_acc_ram #(
    parameter int DEPTH      = 256,
    parameter int WIDTH      = 56,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; pixel 0 of every frame overwrites each entry
    // before it is read back, so clearing it would only cost a reset fan-out.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/global_avg_pool.sv
// Global average pool: accumulates NUM_PIXELS feature-map pixels per channel
// and pushes the rounded per-channel mean, packed LANES per word, to the fc FIFO.
module global_avg_pool
    import mobilenet_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int LANES        = 4,
    parameter int NUM_CHANNELS = FC_TOTAL_COUNT,
    parameter int NUM_PIXELS   = GAP_NUM_PIXELS,
    parameter int ACC_WIDTH    = GAP_ACC_WIDTH,
    parameter int RECIP        = GAP_RECIP
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    global_avg_pool_if.master bus,
    output logic              busy,
    output logic              done
);

    localparam int NUM_WORDS  = NUM_CHANNELS / LANES;
    localparam int WORD_AW    = $clog2(NUM_WORDS);
    localparam int PIX_W      = $clog2(NUM_PIXELS + 1);
    localparam int WORD_BITS  = LANES * DATA_WIDTH;
    localparam int RAM_WIDTH  = LANES * ACC_WIDTH;
    localparam int PROD_WIDTH = ACC_WIDTH + 17;

    localparam logic [WORD_AW-1:0]    LAST_WORD  = WORD_AW'(NUM_WORDS - 1);
    localparam logic [PIX_W-1:0]      PIX_PENULT = PIX_W'(NUM_PIXELS - 2);
    localparam logic [PIX_W-1:0]      PIX_LAST   = PIX_W'(NUM_PIXELS - 1);
    localparam logic [PIX_W-1:0]      PIX_END    = PIX_W'(NUM_PIXELS);
    localparam logic [PROD_WIDTH-1:0] RECIP_P    = PROD_WIDTH'(RECIP);
    localparam logic [PROD_WIDTH-1:0] ROUND_HALF = PROD_WIDTH'(1) << 15;
    localparam logic [PROD_WIDTH-1:0] SAT_MAX    = PROD_WIDTH'((1 << DATA_WIDTH) - 1);

    gap_state_t           state;
    logic [WORD_AW-1:0]   word_idx;
    logic [PIX_W-1:0]     pix_idx;
    logic                 pop;

    // Stage 0 registers (loaded on the pop cycle).
    logic                 s0_valid;
    logic                 s0_first;
    logic                 s0_final;
    logic [WORD_AW-1:0]   s0_word;
    logic [WORD_BITS-1:0] s0_data;

    logic [RAM_WIDTH-1:0] ram_q;
    logic [RAM_WIDTH-1:0] sum_word;
    logic [WORD_BITS-1:0] avg_word;
    logic [PROD_WIDTH-1:0] scaled [LANES];
    logic                 out_last;

    // Once pix_idx reaches NUM_PIXELS every word of the frame has been popped.
    always_comb begin
        pop = 1'b0;
        case (state)
            ACCUM:   pop = !bus.in_empty;
            FINAL:   pop = !bus.in_empty && !bus.out_almost_full && (pix_idx != PIX_END);
            default: pop = 1'b0;
        endcase
    end

    assign bus.in_rd_en = pop;

    gap_acc_ram #(
        .DEPTH (NUM_WORDS),
        .WIDTH (RAM_WIDTH)
    ) u_acc_ram (
        .clock   (clock),
        .wr_en   (s0_valid && !s0_final),
        .wr_addr (s0_word),
        .wr_data (sum_word),
        .rd_addr (word_idx),
        .rd_data (ram_q)
    );

    // NOTE: combinational logic uses blocking assignments, with every output
    // given a default first so no path can infer a latch.
    always_comb begin
        sum_word = '0;
        avg_word = '0;
        scaled   = '{default: '0};
        for (int l = 0; l < LANES; l++) begin
            sum_word[l*ACC_WIDTH +: ACC_WIDTH] =
                (s0_first ? '0 : ram_q[l*ACC_WIDTH +: ACC_WIDTH])
                + ACC_WIDTH'(s0_data[l*DATA_WIDTH +: DATA_WIDTH]);
            // Fixed-point divide by NUM_PIXELS, round half up, clamp to lane range.
            scaled[l] = (PROD_WIDTH'(sum_word[l*ACC_WIDTH +: ACC_WIDTH]) * RECIP_P
                         + ROUND_HALF) >> 16;
            avg_word[l*DATA_WIDTH +: DATA_WIDTH] =
                (scaled[l] > SAT_MAX) ? '1 : scaled[l][DATA_WIDTH-1:0];
        end
    end

    // NOTE: payload registers skip reset; s0_valid alone qualifies them.
    always_ff @(posedge clock) begin
        if (pop) begin
            s0_data  <= bus.in_dout;
            s0_word  <= word_idx;
            s0_first <= (pix_idx == '0);
            s0_final <= (pix_idx == PIX_LAST);
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            word_idx      <= '0;
            pix_idx       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            s0_valid      <= 1'b0;
            out_last      <= 1'b0;
            bus.out_wr_en <= 1'b0;
            bus.out_din   <= '0;
        end else begin
            s0_valid      <= pop;
            bus.out_wr_en <= s0_valid && s0_final;
            out_last      <= s0_valid && s0_final && (s0_word == LAST_WORD);
            if (s0_valid && s0_final) begin
                bus.out_din <= avg_word;
            end
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACCUM;
                        busy     <= 1'b1;
                        word_idx <= '0;
                        pix_idx  <= '0;
                    end
                end
                ACCUM: begin
                    if (pop) begin
                        if (word_idx == LAST_WORD) begin
                            word_idx <= '0;
                            pix_idx  <= pix_idx + 1'b1;
                            if (pix_idx == PIX_PENULT) begin
                                state <= FINAL;
                            end
                        end else begin
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                end
                FINAL: begin
                    if (pop) begin
                        if (word_idx == LAST_WORD) begin
                            word_idx <= '0;
                            pix_idx  <= pix_idx + 1'b1;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                    // The last averaged word is on the bus this cycle.
                    if (out_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_global_avg_pool.sv
// Scoreboard bench for global_avg_pool: frames of directed activation patterns
// with hand-derived averages queued at issue and checked as words are pushed.
module tb_global_avg_pool;
    import mobilenet_pkg::*;

    localparam int NW   = 256;
    localparam int NPIX = 49;
    localparam int POPS = NW * NPIX;

    typedef enum int {M_ONES, M_FF, M_ROUND, M_CHAN, M_TWOS} mode_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    global_avg_pool_if bus ();

    always #5 clock = ~clock;

    global_avg_pool dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .bus   (bus.master),
        .busy  (busy),
        .done  (done)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q [$];
    int push_total = 0;
    int pop_total  = 0;
    int done_total = 0;
    int stall_pops = 0;
    int pop_cnt    = 0;
    bit stall_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] chan_word(input int w);
        logic [31:0] r;
        r = '0;
        for (int n = 0; n < 4; n++) r = lane_pack(r, n, 8'((4 * w + n) % 256));
        return r;
    endfunction

    function automatic logic [31:0] stim_word(input mode_t m, input int pix, input int w);
        case (m)
            M_ONES:  return 32'h0101_0101;
            M_FF:    return 32'hFFFF_FFFF;
            M_ROUND: return {8'h00, 8'd100, (pix < 24) ? 8'd1 : 8'd0, (pix < 25) ? 8'd1 : 8'd0};
            M_CHAN:  return chan_word(w);
            default: return 32'h0202_0202;
        endcase
    endfunction

    // Hand-computed means: 49*1 -> 1, 49*255 -> 255, lanes {25,24,4900} -> {1,0,100},
    // 49*v -> v for any byte v, 49*2 -> 2.
    function automatic logic [31:0] expect_word(input mode_t m, input int w);
        case (m)
            M_ONES:  return 32'h0101_0101;
            M_FF:    return 32'hFFFF_FFFF;
            M_ROUND: return 32'h0064_0001;
            M_CHAN:  return chan_word(w);
            default: return 32'h0202_0202;
        endcase
    endfunction

    // Monitor: samples away from the active edge.
    always @(negedge clock) begin
        if (bus.in_rd_en === 1'b1) begin
            pop_total++;
            if (stall_on) stall_pops++;
        end
        if (done === 1'b1) done_total++;
        if (bus.out_wr_en === 1'b1) begin
            push_total++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_push: got 0x%08h, expected no push", bus.out_din);
            end else begin
                check($sformatf("out_din[%0d]", push_total), bus.out_din, exp_q.pop_front());
            end
        end
    end

    // Offers n_pops words FWFT-style; gaps inserts random empty cycles.
    task automatic feed(input mode_t m, input int n_pops, input bit gaps);
        int guard;
        guard   = 0;
        pop_cnt = 0;
        while (pop_cnt < n_pops && guard < 2 * n_pops + 200) begin
            bus.in_empty = gaps && ($urandom_range(0, 7) == 0);
            bus.in_dout  = stim_word(m, pop_cnt / NW, pop_cnt % NW);
            @(negedge clock);
            if (bus.in_rd_en === 1'b1) pop_cnt++;
            @(posedge clock);
            #1;
            guard++;
        end
        bus.in_empty = 1'b1;
        if (pop_cnt < n_pops) begin
            tests++;
            fails++;
            $display("FAIL feed_timeout: got %0d pops, expected %0d", pop_cnt, n_pops);
        end
    endtask

    task automatic stall_final();
        int guard;
        guard = 0;
        while (pop_cnt < 48 * NW + 20 && guard < 3 * POPS) begin
            @(posedge clock);
            #1;
            guard++;
        end
        check("stall_reached_final", (pop_cnt >= 48 * NW + 20) ? 32'd1 : 32'd0, 32'd1);
        bus.out_almost_full = 1'b1;
        stall_pops          = 0;
        stall_on            = 1'b1;
        repeat (50) @(posedge clock);
        #1;
        bus.out_almost_full = 1'b0;
        stall_on            = 1'b0;
        check("stall_no_pop", stall_pops, 0);
    endtask

    task automatic run_frame(input mode_t m, input bit gaps, input bit stall, input string name);
        int pop0, push0, done0, guard;
        for (int w = 0; w < NW; w++) exp_q.push_back(expect_word(m, w));
        pop0  = pop_total;
        push0 = push_total;
        done0 = done_total;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check({name, "_busy"}, busy, 1'b1);
        if (stall) begin
            fork
                feed(m, POPS, gaps);
                stall_final();
            join
        end else begin
            feed(m, POPS, gaps);
        end
        // Keep offering junk so any pop beyond the frame is counted.
        bus.in_empty = 1'b0;
        bus.in_dout  = 32'hDEAD_BEEF;
        guard = 0;
        while (done_total == done0 && guard < 2000) begin
            @(posedge clock);
            #1;
            guard++;
        end
        bus.in_empty = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check({name, "_pops"}, pop_total - pop0, POPS);
        check({name, "_pushes"}, push_total - push0, NW);
        check({name, "_done_pulses"}, done_total - done0, 1);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        bus.in_empty        = 1'b1;
        bus.in_dout         = '0;
        bus.out_almost_full = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_in_rd_en", bus.in_rd_en, 1'b0);
        check("rst_out_wr_en", bus.out_wr_en, 1'b0);
        check("rst_out_din", bus.out_din, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        run_frame(M_ONES, 1'b0, 1'b0, "ones");
        run_frame(M_FF, 1'b0, 1'b0, "ff");
        run_frame(M_ROUND, 1'b0, 1'b0, "round");
        run_frame(M_CHAN, 1'b1, 1'b1, "chan_stall");

        // Abandon a frame at pixel 20, then run a clean frame.
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        feed(M_TWOS, 20 * NW + 37, 1'b0);
        bus.in_empty = 1'b0;
        bus.in_dout  = 32'h0BAD_0BAD;
        @(negedge clock);
        check("midrst_pre_rd_en", bus.in_rd_en, 1'b1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midrst_rd_en", bus.in_rd_en, 1'b0);
        check("midrst_busy", busy, 1'b0);
        @(posedge clock);
        #1;
        reset        = 1'b0;
        bus.in_empty = 1'b1;
        @(posedge clock);
        #1;
        run_frame(M_TWOS, 1'b0, 1'b0, "twos");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
